// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, types and helpers for the MEM-stage memory controller.
//   RegLen / RamDataLen : request word width and RAM byte width
//   MemSize*            : req_size encodings (3 is treated as word)
//   state_e             : controller FSM states
//   size_to_len()       : transaction length in bytes for a req_size code
package mem_ctrl_pkg;

    localparam int unsigned RegLen     = 32;
    localparam int unsigned RamDataLen = 8;

    localparam logic [RegLen-1:0] ZERO_WORD    = '0;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;

    localparam logic [1:0] MemSizeByte = 2'd0;
    localparam logic [1:0] MemSizeHalf = 2'd1;
    localparam logic [1:0] MemSizeWord = 2'd2;

    typedef enum logic [1:0] {
        IdleState,
        ReadState,
        WriteState,
        DoneState
    } state_e;

    // Byte count of a transaction; the reserved code 3 behaves as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            MemSizeByte: len = 3'd1;
            MemSizeHalf: len = 3'd2;
            default:     len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response channel between the MEM pipeline stage and mem_ctrl.
//   req_valid/req_we/req_size/req_signed/req_addr/req_wdata : request, held until resp_valid
//   busy_o      : stall request back to the pipeline
//   resp_valid  : one-cycle completion pulse
//   resp_rdata  : load result (0 for stores)
// Modports: master = pipeline side, slave = controller side.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy_o;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  busy_o, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output busy_o, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_ctrl_load_ext.sv
// mem_ctrl_load_ext: size/sign extension of an assembled little-endian load word.
//   data     : assembled bytes, byte 0 in bits [7:0]
//   size     : req_size code of the load
//   sign_ext : 1 = sign-extend byte/half results, 0 = zero-fill
//   result   : extended load value (words pass through)
module mem_ctrl_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [RegLen-1:0] data,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [RegLen-1:0] result
);

    always_comb begin
        result = data;
        case (size)
            MemSizeByte: result = {{(RegLen - 8){sign_ext & data[7]}}, data[7:0]};
            MemSizeHalf: result = {{(RegLen - 16){sign_ext & data[15]}}, data[15:0]};
            default:     result = data;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM-stage memory responder over a byte-wide synchronous RAM.
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : request/response channel (mem_ctrl_if.slave)
//   ram_addr   : RAM byte address (0 when idle/done)
//   ram_we     : RAM write strobe
//   ram_dout   : RAM write byte
//   ram_din    : RAM read byte, valid one cycle after its address
// One request at a time; stores go out byte by byte little-endian, loads are
// reassembled then size/sign-extended on the completion cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = RegLen
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_ctrl_if.slave             bus,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [RamDataLen-1:0] ram_dout,
    input  logic [RamDataLen-1:0] ram_din
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RegLen-1:0] asm_q, asm_d;

    logic [ADDR_W-1:0] addr_cur;
    logic [1:0]        byte_idx;
    logic [RegLen-1:0] ext_data;

    // base+cnt wraps modulo 2^ADDR_W by construction.
    assign addr_cur = base_q + ADDR_W'(cnt_q);
    // RAM data trails the address by a cycle, so cnt selects byte cnt-1.
    assign byte_idx = cnt_q[1:0] - 2'd1;

    mem_ctrl_load_ext u_load_ext (
        .data     (asm_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .result   (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IdleState;
            cnt_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            base_q   <= base_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            asm_q    <= asm_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        base_d         = base_q;
        size_d         = size_q;
        signed_d       = signed_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        asm_d          = asm_q;
        bus.busy_o     = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        ram_addr       = '0;
        ram_we         = WriteDisable;
        ram_dout       = '0;

        unique case (state_q)
            IdleState: begin
                bus.busy_o = bus.req_valid;
                if (bus.req_valid) begin
                    base_d   = bus.req_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    we_d     = bus.req_we;
                    wdata_d  = bus.req_wdata;
                    len_d    = size_to_len(bus.req_size);
                    cnt_d    = '0;
                    asm_d    = ZERO_WORD;
                    state_d  = bus.req_we ? WriteState : ReadState;
                end
            end

            WriteState: begin
                bus.busy_o = 1'b1;
                ram_we     = WriteEnable;
                ram_addr   = addr_cur;
                ram_dout   = wdata_q[{cnt_q[1:0], 3'b000} +: RamDataLen];
                if (cnt_q == len_q - 3'd1) begin
                    state_d = DoneState;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            // Runs N+1 cycles: addresses on 0..N-1, captures on 1..N.
            ReadState: begin
                bus.busy_o = 1'b1;
                if (cnt_q < len_q) begin
                    ram_addr = addr_cur;
                end
                if (cnt_q != 3'd0) begin
                    asm_d[{byte_idx, 3'b000} +: RamDataLen] = ram_din;
                end
                if (cnt_q == len_q) begin
                    state_d = DoneState;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            // busy_o stays low so the pipeline advances on this edge.
            DoneState: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = we_q ? DATA_W'(ZERO_WORD) : DATA_W'(ext_data);
                state_d        = IdleState;
            end

            default: state_d = IdleState;
        endcase
    end

endmodule
